hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control.sv | 176 +++++++++++++++++
 tb/tb_hazard_control.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// Pipeline hazard controller: a destination scoreboard for EX/MEM/WB plus a
// HALT/RUN/STALL/FLUSH sequencer that drives PC/BF0 enables and the bubble/flush strobes.
module hazard_control #(
    parameter int CNT_W    = 16,
    parameter int TRACK_WB = 1
) (
    input  logic             clk_HC,
    input  logic             rst_HC,
    input  logic             run_HC,
    input  logic [5:0]       op_ID,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic [4:0]       rd_ID,
    input  logic             branchTaken_MEM,
    output logic             pcWrite,
    output logic             bf0Write,
    output logic             bf0Flush,
    output logic             bf1Bubble,
    output logic             bf2Flush,
    output logic             stall,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    // state | meaning
    // HALT  | pipeline frozen, all outputs low
    // RUN   | normal issue
    // STALL | ID held behind an in-flight producer
    // FLUSH | one cycle after a taken branch, ID holds the flushed NOP
    typedef enum logic [1:0] {S_HALT, S_RUN, S_STALL, S_FLUSH} state_t;

    state_t state, next_state;

    logic       ex_valid, mem_valid, wb_valid;
    logic [4:0] ex_dest, mem_dest, wb_dest;

    logic       reads_rs, reads_rt, writes;
    logic [4:0] dest;
    logic       hit_rs, hit_rt, hazard;

    logic       shift_en, kill_mem, issue_valid, inc_stall, inc_flush;
    logic [4:0] issue_dest;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        writes   = 1'b0;
        dest     = 5'd0;
        case (op_ID)
            6'h00: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                writes   = 1'b1;
                dest     = rd_ID;
            end
            6'h23: begin
                reads_rs = 1'b1;
                writes   = 1'b1;
                dest     = rt_ID;
            end
            6'h2B, 6'h04: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Register 0 is hard-wired, so it can never be a true dependency.
    assign hit_rs = (rs_ID != 5'd0) &&
                    ((ex_valid && ex_dest == rs_ID) ||
                     (mem_valid && mem_dest == rs_ID) ||
                     ((TRACK_WB != 0) && wb_valid && wb_dest == rs_ID));
    assign hit_rt = (rt_ID != 5'd0) &&
                    ((ex_valid && ex_dest == rt_ID) ||
                     (mem_valid && mem_dest == rt_ID) ||
                     ((TRACK_WB != 0) && wb_valid && wb_dest == rt_ID));
    assign hazard = (reads_rs && hit_rs) || (reads_rt && hit_rt);

    always_comb begin
        next_state  = state;
        pcWrite     = 1'b0;
        bf0Write    = 1'b0;
        bf0Flush    = 1'b0;
        bf1Bubble   = 1'b0;
        bf2Flush    = 1'b0;
        stall       = 1'b0;
        shift_en    = 1'b0;
        kill_mem    = 1'b0;
        issue_valid = 1'b0;
        issue_dest  = 5'd0;
        inc_stall   = 1'b0;
        inc_flush   = 1'b0;
        case (state)
            S_HALT: begin
                if (run_HC) next_state = S_RUN;
            end
            S_RUN, S_STALL: begin
                if (!run_HC) begin
                    next_state = S_HALT;
                end else begin
                    shift_en = 1'b1;
                    if (branchTaken_MEM) begin
                        pcWrite    = 1'b1;
                        bf0Write   = 1'b1;
                        bf0Flush   = 1'b1;
                        bf1Bubble  = 1'b1;
                        bf2Flush   = 1'b1;
                        kill_mem   = 1'b1;
                        inc_flush  = 1'b1;
                        next_state = S_FLUSH;
                    end else if (hazard) begin
                        bf1Bubble  = 1'b1;
                        stall      = 1'b1;
                        inc_stall  = 1'b1;
                        next_state = S_STALL;
                    end else begin
                        pcWrite     = 1'b1;
                        bf0Write    = 1'b1;
                        issue_valid = writes;
                        issue_dest  = dest;
                        next_state  = S_RUN;
                    end
                end
            end
            S_FLUSH: begin
                if (!run_HC) begin
                    next_state = S_HALT;
                end else begin
                    shift_en   = 1'b1;
                    pcWrite    = 1'b1;
                    bf0Write   = 1'b1;
                    next_state = S_RUN;
                end
            end
            default: next_state = S_HALT;
        endcase
    end

    always_ff @(posedge clk_HC or posedge rst_HC) begin
        if (rst_HC) state <= S_HALT;
        else        state <= next_state;
    end

    always_ff @(posedge clk_HC or posedge rst_HC) begin
        if (rst_HC) begin
            ex_valid  <= 1'b0;
            ex_dest   <= 5'd0;
            mem_valid <= 1'b0;
            mem_dest  <= 5'd0;
            wb_valid  <= 1'b0;
            wb_dest   <= 5'd0;
        end else if (shift_en) begin
            wb_valid  <= mem_valid;
            wb_dest   <= mem_dest;
            mem_valid <= kill_mem ? 1'b0 : ex_valid;
            mem_dest  <= kill_mem ? 5'd0 : ex_dest;
            ex_valid  <= issue_valid;
            ex_dest   <= issue_valid ? issue_dest : 5'd0;
        end
    end

    always_ff @(posedge clk_HC or posedge rst_HC) begin
        if (rst_HC) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (inc_stall && stallCycles != CNT_MAX) stallCycles <= stallCycles + CNT_ONE;
            if (inc_flush && flushCount != CNT_MAX)  flushCount  <= flushCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: two instances (WB tracked / untracked with narrow
// counters) checked every cycle against a rule-level model, plus directed scenarios.
module tb_hazard_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       br;

    logic        a_pc, a_bf0, a_bf0f, a_bub, a_bf2f, a_stall;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_bf0, b_bf0f, b_bub, b_bf2f, b_stall;
    logic [2:0]  b_sc, b_fc;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hazard_control #(.CNT_W(16), .TRACK_WB(1)) dut_a (
        .clk_HC(clk), .rst_HC(rst), .run_HC(run), .op_ID(op),
        .rs_ID(rs), .rt_ID(rt), .rd_ID(rd), .branchTaken_MEM(br),
        .pcWrite(a_pc), .bf0Write(a_bf0), .bf0Flush(a_bf0f), .bf1Bubble(a_bub),
        .bf2Flush(a_bf2f), .stall(a_stall), .stallCycles(a_sc), .flushCount(a_fc));

    hazard_control #(.CNT_W(3), .TRACK_WB(0)) dut_b (
        .clk_HC(clk), .rst_HC(rst), .run_HC(run), .op_ID(op),
        .rs_ID(rs), .rt_ID(rt), .rd_ID(rd), .branchTaken_MEM(br),
        .pcWrite(b_pc), .bf0Write(b_bf0), .bf0Flush(b_bf0f), .bf1Bubble(b_bub),
        .bf2Flush(b_bf2f), .stall(b_stall), .stallCycles(b_sc), .flushCount(b_fc));

    logic [5:0] flags [2];
    int         sc [2];
    int         fc [2];
    assign flags[0] = {a_pc, a_bf0, a_bf0f, a_bub, a_bf2f, a_stall};
    assign flags[1] = {b_pc, b_bf0, b_bf0f, b_bub, b_bf2f, b_stall};
    assign sc[0] = int'(a_sc);
    assign fc[0] = int'(a_fc);
    assign sc[1] = int'(b_sc);
    assign fc[1] = int'(b_fc);

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Pipeline age 0=EX, 1=MEM, 2=WB; instance k compares the first depth[k] ages.
    bit         halted [2]     = '{1'b1, 1'b1};
    bit         flush_next [2] = '{1'b0, 1'b0};
    bit         pv [2][3];
    logic [4:0] pd [2][3];
    int         msc [2] = '{0, 0};
    int         mfc [2] = '{0, 0};
    int         sat [2] = '{65535, 7};
    int         depth [2] = '{3, 2};

    function automatic void decode(output bit r_s, output bit r_t, output bit w,
                                   output logic [4:0] d);
        r_s = 0; r_t = 0; w = 0; d = 0;
        if (op == 6'h00) begin r_s = 1; r_t = 1; w = 1; d = rd; end
        else if (op == 6'h23) begin r_s = 1; w = 1; d = rt; end
        else if (op == 6'h2B || op == 6'h04) begin r_s = 1; r_t = 1; end
    endfunction

    function automatic bit in_flight(int k, logic [4:0] src);
        if (src == 5'd0) return 0;
        for (int j = 0; j < depth[k]; j++)
            if (pv[k][j] && pd[k][j] == src) return 1;
        return 0;
    endfunction

    function automatic bit model_hz(int k);
        bit r_s, r_t, w;
        logic [4:0] d;
        decode(r_s, r_t, w, d);
        return (r_s && in_flight(k, rs)) || (r_t && in_flight(k, rt));
    endfunction

    // {pcWrite, bf0Write, bf0Flush, bf1Bubble, bf2Flush, stall}
    function automatic logic [5:0] exp_flags(int k);
        if (rst || halted[k] || !run) return 6'b000000;
        if (flush_next[k]) return 6'b110000;
        if (br) return 6'b111110;
        if (model_hz(k)) return 6'b000101;
        return 6'b110000;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                halted[k] = 1; flush_next[k] = 0; msc[k] = 0; mfc[k] = 0;
                for (int j = 0; j < 3; j++) begin pv[k][j] = 0; pd[k][j] = 0; end
            end else if (halted[k]) begin
                if (run) halted[k] = 0;
            end else if (!run) begin
                halted[k] = 1;
                flush_next[k] = 0;
            end else begin
                bit f, b, h, r_s, r_t, w;
                logic [4:0] d;
                decode(r_s, r_t, w, d);
                f = flush_next[k];
                b = br && !f;
                h = !f && !b && model_hz(k);
                pv[k][2] = pv[k][1]; pd[k][2] = pd[k][1];
                pv[k][1] = b ? 1'b0 : pv[k][0];
                pd[k][1] = b ? 5'd0 : pd[k][0];
                pv[k][0] = !f && !b && !h && w;
                pd[k][0] = pv[k][0] ? d : 5'd0;
                if (h && msc[k] < sat[k]) msc[k]++;
                if (b && mfc[k] < sat[k]) mfc[k]++;
                flush_next[k] = b;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [5:0] e;
            e = exp_flags(k);
            chk($sformatf("pcWrite[%0d]", k),     int'(flags[k][5]), int'(e[5]));
            chk($sformatf("bf0Write[%0d]", k),    int'(flags[k][4]), int'(e[4]));
            chk($sformatf("bf0Flush[%0d]", k),    int'(flags[k][3]), int'(e[3]));
            chk($sformatf("bf1Bubble[%0d]", k),   int'(flags[k][2]), int'(e[2]));
            chk($sformatf("bf2Flush[%0d]", k),    int'(flags[k][1]), int'(e[1]));
            chk($sformatf("stall[%0d]", k),       int'(flags[k][0]), int'(e[0]));
            chk($sformatf("stallCycles[%0d]", k), sc[k], msc[k]);
            chk($sformatf("flushCount[%0d]", k),  fc[k], mfc[k]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d);
        op = o; rs = s; rt = t; rd = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt_a, cnt_b;
        run = 0; br = 0;
        drive(6'h3F, 0, 0, 0);
        #1 rst = 1;
        tick(); tick();
        chk("reset_flags_a", int'(flags[0]), 0);
        chk("reset_flags_b", int'(flags[1]), 0);
        chk("reset_sc_a", sc[0], 0);
        rst = 0;
        tick();
        chk("halt_flags_a", int'(flags[0]), 0);
        run = 1;
        tick();

        // independent R-types
        for (int i = 0; i < 6; i++) begin
            drive(6'h00, 5'(10 + i), 5'(20 + i), 5'(1 + i));
            #2 chk("indep_pc_a", int'(a_pc), 1);
            chk("indep_stall_a", int'(a_stall), 0);
            tick();
        end
        chk("indep_sc_a", sc[0], 0);
        chk("indep_fc_a", fc[0], 0);

        // lw $2 ; add $3,$2,$4
        drive(6'h23, 1, 2, 0);
        tick();
        cnt_a = 0; cnt_b = 0;
        drive(6'h00, 2, 4, 3);
        #2 chk("lw_use_first_pc_a", int'(a_pc), 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) #2;
            cnt_a += int'(a_stall);
            cnt_b += int'(b_stall);
            tick();
        end
        drive(6'h3F, 0, 0, 0);
        tick();
        chk("lw_use_len_a", cnt_a, 3);
        chk("lw_use_len_b", cnt_b, 2);
        chk("lw_use_sc_a", sc[0], 3);
        chk("lw_use_sc_b", sc[1], 2);

        // write $0 then read $0
        drive(6'h00, 7, 8, 0);
        tick();
        drive(6'h00, 0, 0, 9);
        #2 chk("zero_reg_stall_a", int'(a_stall), 0);
        tick();
        drive(6'h3F, 0, 0, 0);
        tick(); tick(); tick();

        // taken branch while stalled
        drive(6'h23, 1, 5, 0);
        tick();
        drive(6'h00, 5, 5, 6);
        #2 chk("br_pre_stall_a", int'(a_stall), 1);
        tick();
        br = 1;
        #2 chk("br_flush_flags_a", int'(flags[0]), 6'b111110);
        tick();
        drive(6'h3F, 0, 0, 0);
        #2 chk("br_flushcyc_flags_a", int'(flags[0]), 6'b110000);
        tick();
        br = 0;
        #2 chk("br_after_flags_a", int'(flags[0]), 6'b110000);
        chk("br_fc_a", fc[0], 1);
        chk("br_sc_a", sc[0], 4);
        tick();

        // async reset mid-stall
        drive(6'h23, 1, 6, 0);
        tick();
        drive(6'h00, 6, 0, 7);
        tick();
        #1 rst = 1;
        #1 chk("midrst_flags_a", int'(flags[0]), 0);
        chk("midrst_sc_a", sc[0], 0);
        chk("midrst_fc_a", fc[0], 0);
        drive(6'h3F, 0, 0, 0);
        #1 rst = 0;
        tick();
        drive(6'h00, 6, 6, 7);
        #2 chk("restart_flags_a", int'(flags[0]), 6'b110000);
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] ops [6];
            ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
            ops[4] = 6'h3F; ops[5] = 6'($urandom);
            drive(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            br  = ($urandom_range(0, 9) == 0);
            run = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1;
                #1 rst = 0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
